// File: rtl/hash_out_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hash_out_pkg
// Description : Shared types and helpers for the hash output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package hash_out_pkg;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        SHIFT = 1'b1
    } t_ser_state;

    // Number of output words that make up one hash.
    function automatic int words_per_hash(input int data_width, input int out_width);
        return data_width / out_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with count outputs and same-cycle wr/rd.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_wr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_rd,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_wr_accept,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [$clog2(DEPTH):0]   o_next_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_rd;
    logic             w_wr;
    logic [AW:0]      w_next_count;

    assign w_rd = i_rd && (r_count != '0);
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign w_wr = i_wr && ((r_count != c_depth) || w_rd);

    always_comb begin
        w_next_count = r_count;
        case ({w_wr, w_rd})
            2'b10:   w_next_count = r_count + 1'b1;
            2'b01:   w_next_count = r_count - 1'b1;
            default: w_next_count = r_count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_next_count;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata      = r_mem[r_rd_ptr];
    assign o_wr_accept  = w_wr;
    assign o_count      = r_count;
    assign o_next_count = w_next_count;

endmodule
`default_nettype wire

// File: rtl/hash_out_buffer.sv
`default_nettype none
// ============================================================================
// Module      : hash_out_buffer
// Description : Buffers scheduler hashes and serialises them MSW-first onto a
//               valid/ready stream. Optional macro HASH_OUT_DROP_CNT_EN adds
//               a saturating dropped-write counter on o_drop_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module hash_out_buffer
    import hash_out_pkg::*;
#(
    parameter int DATA_WIDTH   = 256,
    parameter int OUT_WIDTH    = 64,
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 6
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_d_in,
    input  logic                  i_d_in_wr,
    output logic                  o_d_in_rdy,
    output logic [OUT_WIDTH-1:0]  o_d_out,
    output logic                  o_d_out_valid,
    input  logic                  i_d_out_ready,
    output logic                  o_d_out_last,
    output logic                  o_overflow
`ifdef HASH_OUT_DROP_CNT_EN
    ,
    output logic [15:0]           o_drop_cnt
`endif
);

    localparam int WORDS_PER_HASH = words_per_hash(DATA_WIDTH, OUT_WIDTH);
    localparam int WCW            = (WORDS_PER_HASH > 1) ? $clog2(WORDS_PER_HASH) : 1;
    localparam int CNTW           = $clog2(DEPTH) + 1;
    localparam logic [WCW-1:0]  c_last_word   = WCW'(WORDS_PER_HASH - 1);
    localparam logic            c_single_word = (WORDS_PER_HASH == 1);
    localparam logic [CNTW-1:0] c_afull_level = CNTW'(DEPTH - AFULL_MARGIN);

    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_wr_accept;
    logic [CNTW-1:0]       w_count;
    logic [CNTW-1:0]       w_next_count;
    logic                  w_pop;
    logic                  w_handshake;
    logic                  w_wr_drop;

    t_ser_state            r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [WCW-1:0]        r_word_cnt;
    logic                  r_valid;
    logic                  r_last;
    logic                  r_in_rdy;
    logic                  r_overflow;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_wr         (i_d_in_wr),
        .i_wdata      (i_d_in),
        .i_rd         (w_pop),
        .o_rdata      (w_head),
        .o_wr_accept  (w_wr_accept),
        .o_count      (w_count),
        .o_next_count (w_next_count)
    );

    assign w_handshake = r_valid && i_d_out_ready;
    assign w_wr_drop   = i_d_in_wr && !w_wr_accept;

    // Pop on idle, or on the final-word handshake so hashes run back to back.
    always_comb begin
        w_pop = 1'b0;
        if (r_state == EMPTY)
            w_pop = (w_count != '0);
        else if (w_handshake && r_last)
            w_pop = (w_count != '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= EMPTY;
            r_shift    <= '0;
            r_word_cnt <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_pop) begin
                        r_shift    <= w_head;
                        r_word_cnt <= '0;
                        r_valid    <= 1'b1;
                        r_last     <= c_single_word;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_handshake) begin
                        if (!r_last) begin
                            r_shift    <= r_shift << OUT_WIDTH;
                            r_word_cnt <= r_word_cnt + 1'b1;
                            r_last     <= ((r_word_cnt + 1'b1) == c_last_word);
                        end else if (w_pop) begin
                            r_shift    <= w_head;
                            r_word_cnt <= '0;
                            r_last     <= c_single_word;
                        end else begin
                            r_valid    <= 1'b0;
                            r_last     <= 1'b0;
                            r_state    <= EMPTY;
                        end
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_state <= EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_in_rdy   <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_in_rdy <= (w_next_count < c_afull_level);
            if (w_wr_drop) r_overflow <= 1'b1;
        end
    end

`ifdef HASH_OUT_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_drop_cnt <= '0;
        else if (w_wr_drop && (r_drop_cnt != 16'hFFFF))
            r_drop_cnt <= r_drop_cnt + 16'd1;
    end

    assign o_drop_cnt = r_drop_cnt;
`endif

    assign o_d_in_rdy    = r_in_rdy;
    assign o_d_out       = r_shift[DATA_WIDTH-1 -: OUT_WIDTH];
    assign o_d_out_valid = r_valid;
    assign o_d_out_last  = r_last;
    assign o_overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_hash_out_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hash_out_buffer
// Description : Self-checking bench for hash_out_buffer against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hash_out_buffer;

    localparam int DW     = 256;
    localparam int OW     = 64;
    localparam int DEPTH  = 16;
    localparam int MARGIN = 6;
    localparam int WPH    = DW / OW;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic [DW-1:0] i_d_in = '0;
    logic          i_d_in_wr = 1'b0;
    logic          i_d_out_ready = 1'b0;
    logic          o_d_in_rdy;
    logic [OW-1:0] o_d_out;
    logic          o_d_out_valid;
    logic          o_d_out_last;
    logic          o_overflow;
`ifdef HASH_OUT_DROP_CNT_EN
    logic [15:0]   o_drop_cnt;
`endif

    hash_out_buffer #(
        .DATA_WIDTH   (DW),
        .OUT_WIDTH    (OW),
        .DEPTH        (DEPTH),
        .AFULL_MARGIN (MARGIN)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_d_in        (i_d_in),
        .i_d_in_wr     (i_d_in_wr),
        .o_d_in_rdy    (o_d_in_rdy),
        .o_d_out       (o_d_out),
        .o_d_out_valid (o_d_out_valid),
        .i_d_out_ready (i_d_out_ready),
        .o_d_out_last  (o_d_out_last),
        .o_overflow    (o_overflow)
`ifdef HASH_OUT_DROP_CNT_EN
        ,
        .o_drop_cnt    (o_drop_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: hashes waiting in the buffer plus the one being sent.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_cur;
    int            m_widx;
    bit            m_active;
    bit            m_ovf;
    bit            m_rdy;
    int            m_drops;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cur    = '0;
        m_widx   = 0;
        m_active = 1'b0;
        m_ovf    = 1'b0;
        m_rdy    = 1'b1;
        m_drops  = 0;
    endtask

    task automatic model_step(input bit wr, input logic [DW-1:0] d, input bit rdy);
        bit hs, last, pop, acc;
        hs   = m_active && rdy;
        last = (m_widx == WPH - 1);
        pop  = (m_q.size() > 0) && (!m_active || (hs && last));
        acc  = wr && ((m_q.size() < DEPTH) || pop);
        if (pop) begin
            m_cur    = m_q.pop_front();
            m_widx   = 0;
            m_active = 1'b1;
        end else if (hs) begin
            if (last) m_active = 1'b0;
            else      m_widx++;
        end
        if (acc) m_q.push_back(d);
        else if (wr) begin
            m_ovf = 1'b1;
            if (m_drops < 65535) m_drops++;
        end
        m_rdy = (m_q.size() < DEPTH - MARGIN);
    endtask

    task automatic check_outputs();
        check("valid", 64'(o_d_out_valid), 64'(m_active));
        check("last", 64'(o_d_out_last), 64'(m_active && (m_widx == WPH - 1)));
        check("in_rdy", 64'(o_d_in_rdy), 64'(m_rdy));
        check("overflow", 64'(o_overflow), 64'(m_ovf));
        if (m_active) check("dout", o_d_out, m_cur[DW-1-OW*m_widx -: OW]);
`ifdef HASH_OUT_DROP_CNT_EN
        check("drop_cnt", 64'(o_drop_cnt), 64'(m_drops));
`endif
    endtask

    task automatic cycle(input bit wr, input logic [DW-1:0] d, input bit rdy);
        i_d_in_wr     = wr;
        i_d_in        = d;
        i_d_out_ready = rdy;
        @(posedge i_clk);
        if (i_reset) model_reset();
        else         model_step(wr, d, rdy);
        @(negedge i_clk);
        check_outputs();
    endtask

    function automatic logic [DW-1:0] rand_hash();
        logic [DW-1:0] h;
        for (int k = 0; k < DW / 32; k++) h[32*k +: 32] = $urandom;
        return h;
    endfunction

    task automatic do_reset();
        i_reset = 1'b1;
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        i_reset = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge i_clk);

        // Reset and idle
        do_reset();
        check("reset_dout", o_d_out, 64'h0);
        for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b1);

        // Single known hash, MSW first
        cycle(1'b1, 256'h0123456789ABCDEF_FEDCBA9876543210_DEADBEEFCAFEF00D_0F1E2D3C4B5A6978, 1'b1);
        for (int k = 0; k < 7; k++) cycle(1'b0, '0, 1'b1);

        // Back-pressure: fill while stalled, then drain with no gaps
        for (int k = 0; k < 11; k++) cycle(1'b1, rand_hash(), 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b0);
        for (int k = 0; k < 50; k++) cycle(1'b0, '0, 1'b1);

        // Overflow: more writes than buffer + shift register can hold
        for (int k = 0; k < 19; k++) cycle(1'b1, rand_hash(), 1'b0);
        for (int k = 0; k < 75; k++) cycle(1'b0, '0, 1'b1);

        // Full plus pop: write lands on the last-word handshake of a full buffer
        do_reset();
        for (int k = 0; k < 17; k++) cycle(1'b1, rand_hash(), 1'b0);
        for (int k = 0; k < WPH - 1; k++) cycle(1'b0, '0, 1'b1);
        cycle(1'b1, rand_hash(), 1'b1);
        for (int k = 0; k < 2; k++) cycle(1'b0, '0, 1'b0);
        cycle(1'b1, rand_hash(), 1'b0);
        for (int k = 0; k < 75; k++) cycle(1'b0, '0, 1'b1);

        // Random writes and ready toggling
        do_reset();
        for (int k = 0; k < 400; k++)
            cycle($urandom_range(0, 99) < 45, rand_hash(), $urandom_range(0, 99) < 60);

        // Reset mid-hash
        cycle(1'b1, rand_hash(), 1'b0);
        cycle(1'b1, rand_hash(), 1'b0);
        cycle(1'b0, '0, 1'b1);
        i_reset = 1'b1;
        cycle(1'b0, '0, 1'b1);
        i_reset = 1'b0;
        for (int k = 0; k < 5; k++) cycle(1'b0, '0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
